// File: rtl/pry2oht_arb.sv
// rtl/pry2oht_arb.sv - round-robin transfer-locking arbiter with LSB-first priority encoders

module pry2oht_bck #(
    parameter int WIDTH          = 9,
    parameter int SPLIT          = 3,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht
);

    generate
        if (IMPLEMENTATION == 2) begin : g_adder
            // Two's complement isolates the lowest set bit.
            assign oht = req & (~req + WIDTH'(1));
        end else if (IMPLEMENTATION == 1) begin : g_vector
            logic [WIDTH-1:0] oht_t;
            logic             prior_grp;
            logic             in_grp;
            // Groups of SPLIT bits: a bit wins only if no earlier group and no lower bit in its own group requests.
            always_comb begin
                oht_t     = '0;
                prior_grp = 1'b0;
                in_grp    = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i % SPLIT == 0) begin
                        prior_grp = prior_grp | in_grp;
                        in_grp    = 1'b0;
                    end
                    oht_t[i] = req[i] & ~prior_grp & ~in_grp;
                    in_grp   = in_grp | req[i];
                end
            end
            assign oht = oht_t;
        end else begin : g_loop
            logic [WIDTH-1:0] oht_t;
            logic             found;
            // Linear scan from bit 0 upward, first set bit wins.
            always_comb begin
                oht_t = '0;
                found = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (req[i] && !found) begin
                        oht_t[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
            assign oht = oht_t;
        end
    endgenerate

endmodule

module pry2oht_arb #(
    parameter int WIDTH          = 9,
    parameter int SPLIT          = 3,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] lst,
    input  logic             rdy,
    output logic [WIDTH-1:0] gnt,
    output logic             vld,
    output logic [WIDTH-1:0] ack
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] msk_rel;
    logic [WIDTH-1:0] msk_n;
    logic [WIDTH-1:0] req_m;
    logic [WIDTH-1:0] req_mm;
    logic [WIDTH-1:0] cand_m;
    logic [WIDTH-1:0] cand_u;
    logic [WIDTH-1:0] cand;
    logic             xfr;
    logic             rel;

    assign vld = (state == GRANT);
    assign ack = gnt & {WIDTH{rdy}};

    assign xfr = vld & rdy & (|(gnt & req));
    assign rel = xfr & (|(gnt & lst));

    // The releasing requester is excluded so it cannot win twice in a row.
    assign req_m  = vld ? (req & ~gnt) : req;
    assign msk_n  = rel ? msk_rel : msk;
    assign req_mm = req_m & msk_n;
    assign cand   = (|req_mm) ? cand_m : cand_u;

    // Bits strictly above the current grant; top-index grant yields all zero (wrap).
    always_comb begin
        msk_rel    = '0;
        for (int i = 1; i < WIDTH; i++) begin
            msk_rel[i] = msk_rel[i-1] | gnt[i-1];
        end
    end

    pry2oht_bck #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_masked (
        .req (req_mm),
        .oht (cand_m)
    );

    pry2oht_bck #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_unmasked (
        .req (req_m),
        .oht (cand_u)
    );

    // Grant FSM: lock the grant until a last beat transfers, then hand over without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            msk   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && (|req)) begin
                        gnt   <= cand;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        msk <= msk_rel;
                        if (ena && (|req_m)) begin
                            gnt <= cand;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pry2oht_arb.sv
// tb/tb_pry2oht_arb.sv - bench for pry2oht_arb across all priority encoder implementations

module tb_pry2oht_arb;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [3:0] lst;
    logic       rdy;
    logic [3:0] gnt_o [3];
    logic       vld_o [3];
    logic [3:0] ack_o [3];

    int total;
    int passed;
    int m_g;
    int m_last;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        pry2oht_arb #(
            .WIDTH          (4),
            .SPLIT          (3),
            .IMPLEMENTATION (k)
        ) dut (
            .clk (clk),
            .rst (rst),
            .ena (ena),
            .req (req),
            .lst (lst),
            .rdy (rdy),
            .gnt (gnt_o[k]),
            .vld (vld_o[k]),
            .ack (ack_o[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin search starting just above the previous winner, wrapping to index 0.
    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (last + 1 + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] one;
        one = 4'b0001;
        return (m_g < 0) ? 4'b0000 : (one << m_g);
    endfunction

    task automatic model_step();
        logic [3:0] rm;
        logic [3:0] one;
        one = 4'b0001;
        if (rst) begin
            m_g    = -1;
            m_last = -1;
        end else if (m_g < 0) begin
            if (ena && req != 4'b0000) m_g = pick(req, m_last);
        end else if (rdy && req[m_g] && lst[m_g]) begin
            m_last = m_g;
            rm     = req & ~(one << m_g);
            m_g    = (ena && rm != 4'b0000) ? pick(rm, m_last) : -1;
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] l, input logic rd,
                          input logic en, input logic rs);
        @(negedge clk);
        req = r;
        lst = l;
        rdy = rd;
        ena = en;
        rst = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic apply_reset();
        set_in(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        set_in(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_in(4'b0000, 4'b0000, 1'b1, 1'b1, (c == 0));
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== 4'b0000 || vld_o[d] !== 1'b0 || ack_o[d] !== 4'b0000)
                    $display("FAIL reset_idle impl%0d cyc%0d gnt=%b vld=%b ack=%b want 0000/0/0000",
                             d, c, gnt_o[d], vld_o[d], ack_o[d]);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        tick();
        for (int s = 0; s < 5; s++) begin
            set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== seq[s] || vld_o[d] !== 1'b1 || ack_o[d] !== seq[s])
                    $display("FAIL rr_seq impl%0d step%0d gnt=%b vld=%b ack=%b want gnt=ack=%b vld=1",
                             d, s, gnt_o[d], vld_o[d], ack_o[d], seq[s]);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_lock();
        apply_reset();
        set_in(4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_in(4'b0011, (b == 2) ? 4'b0001 : 4'b0000, 1'b1, 1'b1, 1'b0);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== 4'b0001 || ack_o[d] !== 4'b0001)
                    $display("FAIL lock_hold impl%0d beat%0d gnt=%b ack=%b want 0001/0001",
                             d, b, gnt_o[d], ack_o[d]);
                else passed++;
            end
            tick();
        end
        set_in(4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0010 || vld_o[d] !== 1'b1)
                $display("FAIL lock_next impl%0d gnt=%b vld=%b want 0010/1", d, gnt_o[d], vld_o[d]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_in(4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_in((c == 1 || c == 2) ? 4'b0000 : 4'b0100, 4'b1111, 1'b0, 1'b1, 1'b0);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== 4'b0100 || vld_o[d] !== 1'b1 || ack_o[d] !== 4'b0000)
                    $display("FAIL bp_hold impl%0d cyc%0d gnt=%b vld=%b ack=%b want 0100/1/0000",
                             d, c, gnt_o[d], vld_o[d], ack_o[d]);
                else passed++;
            end
            tick();
        end
        set_in(4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0100 || ack_o[d] !== 4'b0100)
                $display("FAIL bp_lst_noreq impl%0d gnt=%b ack=%b want 0100/0100", d, gnt_o[d], ack_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0000 || vld_o[d] !== 1'b0)
                $display("FAIL bp_release impl%0d gnt=%b vld=%b want 0000/0", d, gnt_o[d], vld_o[d]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        set_in(4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b1001, 4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0001)
                $display("FAIL wrap_gnt impl%0d gnt=%b want 0001", d, gnt_o[d]);
            else passed++;
        end
        apply_reset();
        set_in(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0000 || vld_o[d] !== 1'b0)
                $display("FAIL excl_idle impl%0d gnt=%b vld=%b want 0000/0", d, gnt_o[d], vld_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0001 || vld_o[d] !== 1'b1)
                $display("FAIL excl_regrant impl%0d gnt=%b vld=%b want 0001/1", d, gnt_o[d], vld_o[d]);
            else passed++;
        end
    endtask

    task automatic test_enable_midreset();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== 4'b0000)
                    $display("FAIL ena_block impl%0d cyc%0d gnt=%b want 0000", d, c, gnt_o[d]);
                else passed++;
            end
            tick();
        end
        set_in(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0001)
                $display("FAIL ena_hold impl%0d gnt=%b want 0001", d, gnt_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (vld_o[d] !== 1'b0)
                $display("FAIL ena_release_idle impl%0d vld=%b want 0", d, vld_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0010)
                $display("FAIL ena_rr_resume impl%0d gnt=%b want 0010", d, gnt_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0000 || vld_o[d] !== 1'b0)
                $display("FAIL midrst_clear impl%0d gnt=%b vld=%b want 0000/0", d, gnt_o[d], vld_o[d]);
            else passed++;
        end
        tick();
        set_in(4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (gnt_o[d] !== 4'b0010)
                $display("FAIL midrst_regrant impl%0d gnt=%b want 0010", d, gnt_o[d]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] eg;
        logic       rd;
        logic       en;
        logic       rs;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            r  = 4'($urandom);
            l  = 4'($urandom) & 4'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 59) == 0);
            set_in(r, l, rd, en, rs);
            eg = exp_gnt();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (gnt_o[d] !== eg || vld_o[d] !== (m_g >= 0) || ack_o[d] !== (eg & {4{rd}}))
                    $display("FAIL rand impl%0d cyc%0d gnt=%b vld=%b ack=%b want %b/%b/%b",
                             d, c, gnt_o[d], vld_o[d], ack_o[d], eg, (m_g >= 0), eg & {4{rd}});
                else passed++;
            end
            tick();
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        m_g    = -1;
        m_last = -1;
        rst    = 1'b1;
        ena    = 1'b1;
        req    = 4'b0000;
        lst    = 4'b0000;
        rdy    = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_wrap();
        test_enable_midreset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
